// File: rtl/uart_boot_loader.sv
// UART byte-stream boot loader: parses a framed image and writes words to memory.
// Holds the CPU in reset until a frame with a valid checksum is accepted.
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 4096,
  parameter int unsigned TIMEOUT   = 1_000_000,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] word_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, CSUM, DONE, ERR
  } state_t;

  state_t state, nstate;

  logic [1:0]    bidx;
  logic [23:0]   shreg;
  logic [31:0]   len;
  logic [31:0]   widx;
  logic [31:0]   waddr;
  logic [7:0]    csum;
  logic [TW-1:0] timer;

  logic [31:0] word;
  logic        last_byte;
  logic        active;
  logic        expire;
  logic        is_sync;

  assign word      = {rx_data, shreg};
  assign last_byte = (bidx == 2'd3);
  assign active    = state inside {LEN, DATA, CSUM};
  assign expire    = active && (timer == TMAX) && !rx_done;
  assign is_sync   = rx_done && (rx_data == SYNC);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (is_sync) nstate = LEN;
      end
      LEN: begin
        if (rx_done && last_byte) begin
          if (word > MAX_WORDS) nstate = ERR;
          else if (word == 32'd0) nstate = CSUM;
          else nstate = DATA;
        end
      end
      DATA: begin
        if (rx_done && last_byte && (widx == len - 32'd1))
          nstate = CSUM;
      end
      CSUM: begin
        if (rx_done) nstate = (rx_data == csum) ? DONE : ERR;
      end
      default: nstate = IDLE;
    endcase
    if (expire) nstate = ERR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bidx      <= '0;
      shreg     <= '0;
      len       <= '0;
      widx      <= '0;
      waddr     <= BASE_ADDR;
      csum      <= '0;
      timer     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      word_cnt  <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      cpu_hold  <= (nstate != DONE);
      load_done <= (nstate == DONE);
      load_err  <= (nstate == ERR);
      // Timer only runs while a frame is open; a byte always resets it
      if (rx_done || !active) timer <= '0;
      else if (timer != TMAX) timer <= timer + TW'(1);
      if (rx_done) begin
        unique case (state)
          IDLE, DONE, ERR: begin
            if (is_sync) begin
              bidx     <= '0;
              widx     <= '0;
              csum     <= '0;
              word_cnt <= '0;
              waddr    <= BASE_ADDR;
            end
          end
          LEN: begin
            shreg <= word[31:8];
            bidx  <= bidx + 2'd1;
            csum  <= csum + rx_data;
            if (last_byte) len <= word;
          end
          DATA: begin
            shreg <= word[31:8];
            bidx  <= bidx + 2'd1;
            csum  <= csum + rx_data;
            if (last_byte) begin
              mem_we   <= 1'b1;
              mem_addr <= waddr;
              mem_data <= word;
              waddr    <= waddr + 32'd4;
              widx     <= widx + 32'd1;
              word_cnt <= widx[15:0] + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomised scoreboard bench for uart_boot_loader.
// Expected writes are queued by the frame generator and popped by a write monitor.
module tb_uart_boot_loader;

  localparam int          TO   = 40;
  localparam int          MAXW = 16;
  localparam logic [31:0] BASE = 32'h0000_0040;
  localparam logic [7:0]  SY   = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [15:0] word_cnt;

  uart_boot_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW),
    .TIMEOUT(TO),
    .SYNC(SY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_done(rx_done),
    .rx_data(rx_data),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_we(mem_we),
    .cpu_hold(cpu_hold),
    .load_done(load_done),
    .load_err(load_err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [15:0] c;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] tx_words[$];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 mem_addr, mem_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e.a);
        chk("wr_data", mem_data, e.d);
        chk("wr_cnt", 32'(word_cnt), 32'(e.c));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic check_status(input string tag, input bit d, input bit e,
                              input logic [15:0] wc);
    repeat (2) tick();
    chk({tag, "_done"}, 32'(load_done), 32'(d));
    chk({tag, "_err"}, 32'(load_err), 32'(e));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(!d));
    chk({tag, "_wcnt"}, 32'(word_cnt), 32'(wc));
  endtask

  // Model: frame = SYNC, LE count, LE words, 8-bit sum of count+word bytes
  task automatic frame(input string tag, input int n, input bit bad,
                       input bit use_tx, input int max_gap);
    logic [7:0]  sum;
    logic [31:0] w;
    logic [31:0] nl;
    sum = 8'h00;
    nl  = n;
    send_byte(SY, $urandom_range(0, max_gap));
    chk({tag, "_sync_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_sync_done"}, 32'(load_done), 32'd0);
    chk({tag, "_sync_err"}, 32'(load_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      sum = sum + nl[8*i +: 8];
      send_byte(nl[8*i +: 8], $urandom_range(0, max_gap));
    end
    if (n > MAXW) begin
      check_status(tag, 1'b0, 1'b1, 16'd0);
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = use_tx ? tx_words[k] : $urandom;
      exp_q.push_back('{a: BASE + 32'(4 * k), d: w, c: 16'(k + 1)});
      for (int i = 0; i < 4; i++) begin
        sum = sum + w[8*i +: 8];
        send_byte(w[8*i +: 8], $urandom_range(0, max_gap));
      end
    end
    send_byte(bad ? sum + 8'd1 : sum, 0);
    check_status(tag, !bad, bad, 16'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  sum;
    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) tick();
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_wcnt", 32'(word_cnt), 32'd0);
    reset = 1'b0;
    tick();

    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 2);
    chk("junk_hold", 32'(cpu_hold), 32'd1);
    chk("junk_done", 32'(load_done), 32'd0);

    tx_words = '{32'h1234_5678, 32'hDEAD_BEEF};
    frame("nominal", 2, 1'b0, 1'b1, 0);
    frame("badsum", 2, 1'b1, 1'b1, 1);
    frame("after_err", $urandom_range(1, 5), 1'b0, 1'b0, 2);
    frame("reload", $urandom_range(1, 5), 1'b0, 1'b0, 2);
    frame("len0", 0, 1'b0, 1'b0, 1);
    frame("len_max", MAXW, 1'b0, 1'b0, 0);
    frame("len_over", MAXW + 1, 1'b0, 1'b0, 1);

    // Byte landing exactly on the expiry cycle keeps the frame alive
    sum = 8'h01;
    w   = $urandom;
    send_byte(SY, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    exp_q.push_back('{a: BASE, d: w, c: 16'd1});
    for (int i = 0; i < 4; i++) begin
      sum = sum + w[8*i +: 8];
      send_byte(w[8*i +: 8], 0);
      if (i == 1 || i == 2) begin
        repeat (TO - 1) tick();
        chk("to_edge_err", 32'(load_err), 32'd0);
        tick();
      end
    end
    send_byte(sum, 0);
    check_status("to_alive", 1'b1, 1'b0, 16'd1);

    // One idle cycle more and the frame is rejected
    send_byte(SY, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    repeat (TO) tick();
    chk("to_pre_err", 32'(load_err), 32'd0);
    tick();
    chk("to_err", 32'(load_err), 32'd1);
    chk("to_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    check_status("to_ignored", 1'b0, 1'b1, 16'd0);

    // Reset coincides with the 4th data byte: no write may appear
    send_byte(SY, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 1);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    reset   = 1'b1;
    rx_data = 8'h04;
    rx_done = 1'b1;
    tick();
    reset   = 1'b0;
    rx_done = 1'b0;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_data", mem_data, 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_wcnt", 32'(word_cnt), 32'd0);
    tick();
    frame("post_rst", 3, 1'b0, 1'b0, 1);

    for (int r = 0; r < 8; r++)
      frame("rand", $urandom_range(0, MAXW + 2),
            ($urandom_range(0, 3) == 0), 1'b0, 2);

    repeat (4) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
